// File: rtl/lfsr_stream_checker_if.sv
// Stream, control and status bundle between an LFSR source/observer and lfsr_stream_checker.
interface lfsr_stream_checker_if #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] DATA;
  logic             VALID;
  logic             CLEAR;
  logic             LOCKED;
  logic             LOCK_LOST;
  logic [CNT_W-1:0] ERR_COUNT;
  logic             STUCK;
  logic [WIDTH-1:0] FIRST_BAD;

  modport master (
    output DATA, VALID, CLEAR,
    input  LOCKED, LOCK_LOST, ERR_COUNT, STUCK, FIRST_BAD
  );

  modport slave (
    input  DATA, VALID, CLEAR,
    output LOCKED, LOCK_LOST, ERR_COUNT, STUCK, FIRST_BAD
  );
endinterface

// File: rtl/lfsr_stream_checker.sv
// Predicts each word of a 64-bit XNOR LFSR stream (taps 0, 8, 13, 31) and reports lock, errors and lock-up.
// Optional first-bad-word capture enabled by defining MCPNR_LFSR_CHK_FIRST_BAD_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | after reset; next VALID word only seeds the prediction
// S_ACQ    | counting consecutive correct predictions toward lock
// S_LOCKED | locked; mispredictions are counted, LOSS_COUNT in a row drop lock
module lfsr_stream_checker #(
  parameter int WIDTH      = 64,
  parameter int LOCK_COUNT = 4,
  parameter int LOSS_COUNT = 2,
  parameter int CNT_W      = 8
) (
  input logic CLK,
  input logic RST,
  lfsr_stream_checker_if.slave bus
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(LOSS_COUNT + 1);
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_COUNT - 1);
  localparam logic [BW-1:0] BAD_LAST  = BW'(LOSS_COUNT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACQ, S_LOCKED} state_t;

  state_t           state;
  logic [WIDTH-1:0] pred;
  logic [GW-1:0]    good_run;
  logic [BW-1:0]    bad_run;
  logic             locked;
  logic             lock_lost;
  logic [CNT_W-1:0] err_count;
  logic             stuck;

  logic [WIDTH-1:0] pred_next;
  logic             match;
  logic             all_ones;
  logic             is_zero;
  logic             err_event;

  assign pred_next = {bus.DATA[0] ^ bus.DATA[8] ^ bus.DATA[13] ^ bus.DATA[31] ^ 1'b1,
                      bus.DATA[WIDTH-1:1]};
  assign match     = (bus.DATA == pred);
  assign all_ones  = &bus.DATA;
  assign is_zero   = ~|bus.DATA;
  // An all-zero word while locked is an upstream reset, not a counted error.
  assign err_event = bus.VALID && (state == S_LOCKED) && !all_ones && !match && !is_zero;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= S_IDLE;
      pred      <= '0;
      good_run  <= '0;
      bad_run   <= '0;
      locked    <= 1'b0;
      lock_lost <= 1'b0;
      err_count <= '0;
      stuck     <= 1'b0;
    end else begin
      lock_lost <= 1'b0;
      if (bus.VALID) begin
        pred <= pred_next;
        // All-ones is a fixed point of the XNOR LFSR, so it must never count as lock.
        if (all_ones) begin
          state    <= S_ACQ;
          locked   <= 1'b0;
          good_run <= '0;
          bad_run  <= '0;
        end else begin
          case (state)
            S_IDLE: begin
              state    <= S_ACQ;
              good_run <= '0;
            end
            S_ACQ: begin
              if (match) begin
                if (good_run == GOOD_LAST) begin
                  state    <= S_LOCKED;
                  locked   <= 1'b1;
                  good_run <= '0;
                  bad_run  <= '0;
                end else begin
                  good_run <= good_run + 1'b1;
                end
              end else begin
                good_run <= '0;
              end
            end
            S_LOCKED: begin
              if (match) begin
                bad_run <= '0;
              end else if (is_zero) begin
                state    <= S_ACQ;
                locked   <= 1'b0;
                good_run <= '0;
                bad_run  <= '0;
              end else if (bad_run == BAD_LAST) begin
                state     <= S_ACQ;
                locked    <= 1'b0;
                lock_lost <= 1'b1;
                good_run  <= '0;
                bad_run   <= '0;
              end else begin
                bad_run <= bad_run + 1'b1;
              end
            end
            default: state <= S_IDLE;
          endcase
        end
      end

      if (bus.CLEAR) begin
        err_count <= '0;
      end else if (err_event && (err_count != {CNT_W{1'b1}})) begin
        err_count <= err_count + 1'b1;
      end

      if (bus.VALID && all_ones) begin
        stuck <= 1'b1;
      end else if (bus.CLEAR) begin
        stuck <= 1'b0;
      end
    end
  end

  assign bus.LOCKED    = locked;
  assign bus.LOCK_LOST = lock_lost;
  assign bus.ERR_COUNT = err_count;
  assign bus.STUCK     = stuck;

`ifdef MCPNR_LFSR_CHK_FIRST_BAD_EN
  logic [WIDTH-1:0] first_bad;
  logic             fb_taken;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      first_bad <= '0;
      fb_taken  <= 1'b0;
    end else if (bus.CLEAR) begin
      first_bad <= '0;
      fb_taken  <= 1'b0;
    end else if (err_event && !fb_taken) begin
      first_bad <= bus.DATA;
      fb_taken  <= 1'b1;
    end
  end

  assign bus.FIRST_BAD = first_bad;
`else
  assign bus.FIRST_BAD = '0;
`endif

endmodule

// File: doc/lfsr_stream_checker.md
Name: lfsr_stream_checker

Overview:
- Downstream consumer of the 64-bit free-running XNOR LFSR stage.
- Samples the LFSR output word, predicts each next word, and reports lock status, error counts and lock-up conditions to a light bank.
- Lets a switch-driven LFSR be verified in-world without reading all 64 lights by eye.

Parameters:
- WIDTH, 64, LFSR word width; taps fixed at bits 0, 8, 13, 31; WIDTH must be >= 32.
- LOCK_COUNT, 4, consecutive correct predictions needed to declare lock.
- LOSS_COUNT, 2, consecutive mispredictions in LOCKED that drop lock.
- CNT_W, 8, width of the saturating error counter.

Ports:
- CLK  in  1  rising-edge clock, shared with the LFSR stage.
- RST  in  1  asynchronous, active-low reset.
- DATA  in  WIDTH  LFSR output word.
- VALID  in  1  DATA holds a new LFSR word this cycle; CLK-enable from the upstream switch.
- CLEAR  in  1  synchronous clear of ERR_COUNT and STUCK.
- LOCKED  out  1  checker is locked to the stream.
- LOCK_LOST  out  1  one-cycle pulse when leaving LOCKED because of errors.
- ERR_COUNT  out  CNT_W  saturating count of mispredictions while LOCKED.
- STUCK  out  1  sticky flag: all-ones lock-up word seen.
- FIRST_BAD  out  WIDTH  first mismatching word (see Optional Feature).

Behaviour:
- Prediction function: f(D) = {D[0]^D[8]^D[13]^D[31]^1, D[WIDTH-1:1]}.
- On every VALID, PRED <= f(DATA), regardless of match. Resync is therefore implicit.
- With VALID low, all state holds.
- RST low (asynchronous):
  - state=IDLE, PRED=0, good_run=0, bad_run=0.
  - LOCKED=0, LOCK_LOST=0, ERR_COUNT=0, STUCK=0, FIRST_BAD=0.
- match = (DATA == PRED). All outputs are registered, so there is one cycle of latency from the VALID edge.
- State machine:
  - IDLE: first VALID loads PRED; go to ACQ with good_run=0. No comparison is made.
  - ACQ, VALID & match: good_run++. When good_run reaches LOCK_COUNT, go to LOCKED; LOCKED=1 next cycle.
  - ACQ, VALID & !match: good_run=0, stay in ACQ. ERR_COUNT is not touched.
  - LOCKED, VALID & match: bad_run=0.
  - LOCKED, VALID & !match & DATA!=0: ERR_COUNT++ (saturates at all-ones); bad_run++. When bad_run reaches LOSS_COUNT: go to ACQ, LOCKED=0, LOCK_LOST=1 for one cycle, good_run=0, bad_run=0.
  - LOCKED, VALID & DATA==0 & !match: treated as an upstream reset. Go to ACQ, no error, no LOCK_LOST.
- STUCK:
  - Set on any VALID with DATA all-ones. All-ones is self-consistent under f, so match alone cannot detect it.
  - While DATA is all-ones, the state stays out of LOCKED: LOCKED is forced to 0 and the state goes to ACQ.
- CLEAR:
  - Zeroes ERR_COUNT and STUCK. Does not change state.
  - CLEAR together with an error-counting VALID: CLEAR wins, ERR_COUNT=0.
  - CLEAR together with an all-ones VALID: STUCK=1 (the set wins).
- Mid-operation RST low returns to IDLE immediately. The first word after reset is only captured, never counted.

Optional Feature:
- Macro: MCPNR_LFSR_CHK_FIRST_BAD_EN.
- Defined:
  - FIRST_BAD latches DATA on the first error-counted misprediction after reset or CLEAR, then holds.
  - CLEAR zeroes it and re-arms the capture.
- Undefined: FIRST_BAD is tied to 0 and no capture register is built.

Test Plan:
- Reset, then VALID words 0x0, 0x8000000000000000, 0xC000000000000000, 0xE000000000000000, 0xF000000000000000 -> LOCKED=1 in the cycle after the 5th VALID; ERR_COUNT=0.
- While locked, inject one wrong word 0x1234, then continue with f(0x1234) -> ERR_COUNT=1, LOCKED stays 1, LOCK_LOST never pulses. With the macro: FIRST_BAD=0x1234.
- While locked, inject two consecutive words that violate f -> LOCK_LOST pulses exactly once, LOCKED=0, ERR_COUNT=2. Resume a valid sequence -> relock after 4 matches.
- While locked, VALID DATA=0 (upstream RST) -> LOCKED=0, ERR_COUNT unchanged, no LOCK_LOST. Relock after 4 further valid words.
- VALID all-ones twice -> STUCK=1, LOCKED=0. CLEAR -> STUCK=0 and ERR_COUNT=0. Force 260 errors with CNT_W=8 -> ERR_COUNT saturates at 255.
- Assert RST low asynchronously between clock edges while locked -> all outputs 0 immediately. VALID low for 10 cycles -> no output changes.
